ss_capture: RTL and testbench

SS_CAPTURE -- requirements
Module: ss_capture

---
 rtl/ss_pkg.sv | 23 ++
 rtl/ss_decode.sv | 32 +++
 rtl/ss_capture.sv | 156 +++++++++++++++
 tb/tb_ss_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared constants and types for the seven-segment capture block.
package ss_pkg;

  // Every segment off (active-low bus).
  localparam logic [6:0] BLANK_PATTERN = 7'h7F;

  // Active-low gfedcba glyphs for hex digits 0..F (index = nibble value).
  // Each entry is the bitwise inverse of the familiar active-high code
  // 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  localparam logic [15:0][6:0] GLYPH_AL = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } ss_state_e;

endpackage

// File: rtl/ss_decode.sv
// Combinational glyph lookup: one 7-bit active-low pattern to a hex nibble.
import ss_pkg::*;

module ss_decode (
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  logic matched;

  // Match the pattern against the blank code, then the 16 hex glyphs.
  always_comb begin
    nibble  = '0;
    blank   = 1'b0;
    invalid = 1'b0;
    matched = 1'b0;
    if (pattern == BLANK_PATTERN) begin
      blank = 1'b1;
    end else begin
      for (int unsigned g = 0; g < 16; g++) begin
        if (pattern == GLYPH_AL[g]) begin
          nibble  = 4'(g);
          matched = 1'b1;
        end
      end
      invalid = ~matched;
    end
  end

endmodule

// File: rtl/ss_capture.sv
// Snapshot a multi-digit seven-segment bus and decode it one digit per cycle.
import ss_pkg::*;

module ss_capture #(
  parameter int NUM_DISPLAYS = 6,
  parameter int NUM_SEGMENTS = 8
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic                                      capture,
  input  logic [NUM_DISPLAYS-1:0][NUM_SEGMENTS-1:0] SS_in,
  input  logic                                      ack,
  output logic [4*NUM_DISPLAYS-1:0]                 number,
  output logic [NUM_DISPLAYS-1:0]                   blank_mask,
  output logic [NUM_DISPLAYS-1:0]                   invalid_mask,
  output logic [NUM_DISPLAYS-1:0]                   dp_mask,
  output logic                                      valid,
  output logic                                      busy
);

  localparam int IDX_W = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DISPLAYS - 1);

  ss_state_e                                  state_q, state_d;
  logic [IDX_W-1:0]                           idx_q, idx_d;
  logic [NUM_DISPLAYS-1:0][NUM_SEGMENTS-1:0]  snap_q, snap_d;
  logic [NUM_DISPLAYS-1:0][3:0]               work_num_q, work_num_d;
  logic [NUM_DISPLAYS-1:0]                    work_blank_q, work_blank_d;
  logic [NUM_DISPLAYS-1:0]                    work_inv_q, work_inv_d;
  logic [NUM_DISPLAYS-1:0]                    work_dp_q, work_dp_d;
  logic [NUM_DISPLAYS-1:0][3:0]               number_q, number_d;
  logic [NUM_DISPLAYS-1:0]                    blank_q, blank_d;
  logic [NUM_DISPLAYS-1:0]                    inv_q, inv_d;
  logic [NUM_DISPLAYS-1:0]                    dp_q, dp_d;

  logic [NUM_SEGMENTS-1:0] cur_seg;
  logic [6:0]              cur_pattern;
  logic                    cur_dp;
  logic [3:0]              dec_nibble;
  logic                    dec_blank;
  logic                    dec_invalid;
  logic                    start;

  // Select the snapshot digit under the scan index; missing segments read as off.
  always_comb begin
    cur_seg     = snap_q[idx_q];
    cur_pattern = BLANK_PATTERN;
    for (int unsigned b = 0; b < 7; b++) begin
      if (b < NUM_SEGMENTS) cur_pattern[b] = cur_seg[b];
    end
  end

  if (NUM_SEGMENTS >= 8) begin : g_dp
    assign cur_dp = ~cur_seg[7];
  end else begin : g_no_dp
    assign cur_dp = 1'b0;
  end

  ss_decode u_decode (
    .pattern (cur_pattern),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  // Next-state logic: accept captures, scan one digit per cycle, publish on the last.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    work_num_d   = work_num_q;
    work_blank_d = work_blank_q;
    work_inv_d   = work_inv_q;
    work_dp_d    = work_dp_q;
    number_d     = number_q;
    blank_d      = blank_q;
    inv_d        = inv_q;
    dp_d         = dp_q;
    start        = 1'b0;

    case (state_q)
      ST_IDLE: start = capture;
      ST_SCAN: begin
        work_num_d[idx_q]   = dec_nibble;
        work_blank_d[idx_q] = dec_blank;
        work_inv_d[idx_q]   = dec_invalid;
        work_dp_d[idx_q]    = cur_dp;
        if (idx_q == LAST_IDX) begin
          // Publish includes the digit decoded this very cycle.
          state_d  = ST_DONE;
          idx_d    = '0;
          number_d = work_num_d;
          blank_d  = work_blank_d;
          inv_d    = work_inv_d;
          dp_d     = work_dp_d;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (ack) begin
          start   = capture;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d      = ST_SCAN;
      idx_d        = '0;
      snap_d       = SS_in;
      work_num_d   = '0;
      work_blank_d = '0;
      work_inv_d   = '0;
      work_dp_d    = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_q       <= '1;
      work_num_q   <= '0;
      work_blank_q <= '0;
      work_inv_q   <= '0;
      work_dp_q    <= '0;
      number_q     <= '0;
      blank_q      <= '0;
      inv_q        <= '0;
      dp_q         <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      work_num_q   <= work_num_d;
      work_blank_q <= work_blank_d;
      work_inv_q   <= work_inv_d;
      work_dp_q    <= work_dp_d;
      number_q     <= number_d;
      blank_q      <= blank_d;
      inv_q        <= inv_d;
      dp_q         <= dp_d;
    end
  end

  assign number       = number_q;
  assign blank_mask   = blank_q;
  assign invalid_mask = inv_q;
  assign dp_mask      = dp_q;
  assign valid        = (state_q == ST_DONE);
  assign busy         = (state_q == ST_SCAN);

endmodule

// File: tb/tb_ss_capture.sv
// Scoreboard bench for ss_capture: driver pushes expected results, monitor checks on valid.
module tb_ss_capture;

  localparam int ND = 6;
  localparam int NS = 8;

  logic                   CLK = 1'b0;
  logic                   nRST;
  logic                   capture;
  logic                   ack;
  logic [ND-1:0][NS-1:0]  SS_in;
  logic [4*ND-1:0]        number;
  logic [ND-1:0]          blank_mask, invalid_mask, dp_mask;
  logic                   valid, busy;

  ss_capture #(.NUM_DISPLAYS(ND), .NUM_SEGMENTS(NS)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .capture      (capture),
    .SS_in        (SS_in),
    .ack          (ack),
    .number       (number),
    .blank_mask   (blank_mask),
    .invalid_mask (invalid_mask),
    .dp_mask      (dp_mask),
    .valid        (valid),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [4*ND-1:0] num;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   inv;
    logic [ND-1:0]   dp;
    int unsigned     due;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold;
  int   vectors     = 0;
  int   miscompares = 0;
  logic valid_prev  = 1'b0;

  // Active-high gfedcba codes for hex 0..F.
  int unsigned GLY[16] = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66, 32'h6D, 32'h7D, 32'h07,
                           32'h7F, 32'h6F, 32'h77, 32'h7C, 32'h39, 32'h5E, 32'h79, 32'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: invert the bus to "lit" segments, look up the lit set in the hex table.
  function automatic exp_t ref_model(input logic [ND-1:0][NS-1:0] seg, input int unsigned due);
    exp_t e;
    logic [6:0] lit;
    logic [6:0] code;
    bit found;
    e.num = '0; e.blank = '0; e.inv = '0; e.dp = '0; e.due = due;
    for (int i = 0; i < ND; i++) begin
      lit = ~seg[i][6:0];
      if (lit == 7'd0) begin
        e.blank[i] = 1'b1;
      end else begin
        found = 0;
        for (int j = 0; j < 16; j++) begin
          code = GLY[j][6:0];
          if (code == lit) begin
            e.num[4*i +: 4] = 4'(j);
            found = 1;
          end
        end
        if (!found) e.inv[i] = 1'b1;
      end
      e.dp[i] = ~seg[i][7];
    end
    return e;
  endfunction

  function automatic logic [7:0] glyph_byte(input int unsigned d, input logic dp_lit);
    logic [6:0] code;
    code = GLY[d][6:0];
    return {~dp_lit, ~code};
  endfunction

  function automatic logic [7:0] rand_digit();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 12)      return glyph_byte($urandom_range(0, 15), 1'($urandom_range(0, 1)));
    else if (r < 15) return {1'($urandom_range(0, 1)), 7'h7F};
    else             return 8'($urandom);
  endfunction

  function automatic logic [ND-1:0][NS-1:0] rand_bus();
    logic [ND-1:0][NS-1:0] b;
    for (int i = 0; i < ND; i++) b[i] = rand_digit();
    return b;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [ND-1:0][NS-1:0] pat, input logic with_ack);
    SS_in   = pat;
    capture = 1'b1;
    ack     = with_ack;
    step();
    exp_q.push_back(ref_model(pat, cyc + ND));
    capture = 1'b0;
    ack     = 1'b0;
    check("busy_after_capture", busy, 1);
  endtask

  task automatic scan(input bit noisy);
    for (int k = 0; k < ND; k++) begin
      if (noisy) begin
        SS_in   = rand_bus();
        capture = 1'($urandom_range(0, 1));
        ack     = 1'($urandom_range(0, 1));
      end
      step();
      check("busy_during_scan", busy, (k < ND - 1) ? 1 : 0);
    end
    capture = 1'b0;
    ack     = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("valid_after_ack", valid, 0);
    check("busy_after_ack", busy, 0);
  endtask

  task automatic do_reset(input int cycles);
    nRST = 1'b0;
    repeat (cycles) step();
    nRST = 1'b1;
    exp_q.delete();
    hold.num = '0; hold.blank = '0; hold.inv = '0; hold.dp = '0; hold.due = 0;
    check("rst_number", number, 0);
    check("rst_blank", blank_mask, 0);
    check("rst_invalid", invalid_mask, 0);
    check("rst_dp", dp_mask, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
  endtask

  // Monitor: pop an expectation on each rising valid; outputs must always equal the last result.
  always @(negedge CLK) begin
    if (!nRST) begin
      valid_prev = 1'b0;
    end else begin
      if (valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          hold = exp_q.pop_front();
          check("latency", cyc, hold.due);
        end
      end
      check("out_number", number, hold.num);
      check("out_blank", blank_mask, hold.blank);
      check("out_invalid", invalid_mask, hold.inv);
      check("out_dp", dp_mask, hold.dp);
      valid_prev = valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ND-1:0][NS-1:0] pat;
    bit chain;

    nRST = 1'b0; capture = 1'b0; ack = 1'b0; SS_in = '1;
    hold.num = '0; hold.blank = '0; hold.inv = '0; hold.dp = '0; hold.due = 0;
    do_reset(2);

    // "123456": digit0 = '6' ... digit5 = '1', dp off.
    for (int i = 0; i < ND; i++) pat[i] = glyph_byte(6 - i, 1'b0);
    issue(pat, 1'b0);
    scan(0);
    check("d123456_number", number, 24'h123456);
    check("d123456_masks", {blank_mask, invalid_mask, dp_mask}, 0);
    do_ack();

    // Blank, all-lit-with-dp, and a lone segment d.
    pat[0] = glyph_byte(0, 1'b0);
    pat[1] = 8'hF7;
    pat[2] = 8'hFF;
    pat[3] = glyph_byte(3, 1'b0);
    pat[4] = 8'h00;
    pat[5] = glyph_byte(5, 1'b0);
    issue(pat, 1'b0);
    scan(0);
    check("edge_number", number, 24'h583000);
    check("edge_blank", blank_mask, 6'b000100);
    check("edge_invalid", invalid_mask, 6'b000010);
    check("edge_dp", dp_mask, 6'b010000);
    repeat (2) step();

    // In DONE: ack+capture with "ABCDEF" chains straight into a new scan.
    for (int i = 0; i < ND; i++) pat[i] = glyph_byte(15 - i, 1'b0);
    issue(pat, 1'b1);
    check("chain_valid_low", valid, 0);
    scan(1);
    check("chain_number", number, 24'hABCDEF);
    do_ack();

    // Reset at scan index 3 discards the in-flight result.
    issue(rand_bus(), 1'b0);
    repeat (3) step();
    do_reset(1);
    repeat (10) begin
      capture = 1'b0;
      ack     = 1'($urandom_range(0, 1));
      SS_in   = rand_bus();
      step();
    end
    ack = 1'b0;
    check("post_reset_idle_valid", valid, 0);

    // Randomised traffic with ignored captures/acks and occasional chaining.
    chain = 0;
    for (int t = 0; t < 40; t++) begin
      if (!chain) begin
        repeat ($urandom_range(0, 3)) begin
          ack   = 1'($urandom_range(0, 1));
          SS_in = rand_bus();
          step();
        end
      end
      issue(rand_bus(), chain);
      scan(1);
      repeat ($urandom_range(0, 3)) begin
        capture = 1'($urandom_range(0, 1));
        SS_in   = rand_bus();
        step();
        check("done_holds_valid", valid, 1);
      end
      capture = 1'b0;
      chain = (t < 39) && ($urandom_range(0, 2) == 0);
      if (!chain) do_ack();
    end

    repeat (5) step();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
